// File: rtl/mem_stage_pkg.sv
// Shared definitions for the EXE->MEM and MEM->WB pipeline buses.
// The field offsets are also used by the EXE and WB stages, so the bus
// layouts must stay in step with those stages.
package mem_stage_pkg;

  localparam int EM_BUS_W = 76;
  localparam int MW_BUS_W = 70;

  // EXE->MEM bus field offsets, bit 0 is the LSB
  localparam int EM_LD_W         = 0;
  localparam int EM_LD_HU        = 1;
  localparam int EM_LD_H         = 2;
  localparam int EM_LD_BU        = 3;
  localparam int EM_LD_B         = 4;
  localparam int EM_PC_LSB       = 5;
  localparam int EM_ALU_LSB      = 37;
  localparam int EM_DEST_LSB     = 69;
  localparam int EM_GR_WE        = 74;
  localparam int EM_RES_FROM_MEM = 75;

  // MEM->WB bus field offsets
  localparam int MW_PC_LSB     = 0;
  localparam int MW_RESULT_LSB = 32;
  localparam int MW_DEST_LSB   = 64;
  localparam int MW_GR_WE      = 69;

  // Load-type flags; one-hot, or all zero for a non-load
  typedef struct packed {
    logic ld_b;
    logic ld_bu;
    logic ld_h;
    logic ld_hu;
    logic ld_w;
  } ld_op_t;

  // Field view of the EXE->MEM bus, MSB first
  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    ld_op_t      ld;
  } em_bus_t;

  // Field view of the MEM->WB bus, MSB first
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } mw_bus_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extraction: picks the addressed byte or half out of the
// SRAM word and sign/zero extends it to 32 bits.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  a,
  input  ld_op_t      ld,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select; half loads ignore a[0] since unaligned halves are never issued
  always_comb begin
    byte_sel = rd[7:0];
    case (a)
      2'b00:   byte_sel = rd[7:0];
      2'b01:   byte_sel = rd[15:8];
      2'b10:   byte_sel = rd[23:16];
      default: byte_sel = rd[31:24];
    endcase
    half_sel = a[1] ? rd[31:16] : rd[15:0];
  end

  // Extension per load type; zero when no load flag is set
  always_comb begin
    load_data = '0;
    if (ld.ld_w)
      load_data = rd;
    else if (ld.ld_b)
      load_data = ext8(byte_sel, 1'b1);
    else if (ld.ld_bu)
      load_data = ext8(byte_sel, 1'b0);
    else if (ld.ld_h)
      load_data = ext16(half_sel, 1'b1);
    else if (ld.ld_hu)
      load_data = ext16(half_sel, 1'b0);
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Latches the EXE->MEM bus, extracts load
// data from the synchronous SRAM read port and hands the result to WB.
// The SRAM word is only valid in the first cycle an instruction sits in
// MEM, so it is captured then and replayed while WB stalls the stage.
module mem_stage #(
  parameter int EM_BUS_W = mem_stage_pkg::EM_BUS_W,
  parameter int MW_BUS_W = mem_stage_pkg::MW_BUS_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                EXE_to_MEM_valid,
  input  logic [EM_BUS_W-1:0] EXE_to_MEM_bus,
  output logic                MEM_allow,
  input  logic [31:0]         data_sram_rdata,
  input  logic                WB_allow,
  output logic                MEM_to_WB_valid,
  output logic [MW_BUS_W-1:0] MEM_to_WB_bus,
  output logic [4:0]          MEM_dest_bus,
  output logic [31:0]         MEM_value_bus
);
  import mem_stage_pkg::*;

  logic        mem_valid;
  logic        mem_go;
  logic        accept;
  logic        fresh;
  em_bus_t     bus_r;
  logic [31:0] rdata_hold;
  logic [31:0] rd;
  logic [31:0] load_data;
  logic [31:0] final_result;
  mw_bus_t     mw_bus;

  // Single-cycle stage: always done once occupied
  assign mem_go          = 1'b1;
  assign MEM_allow       = ~mem_valid | (mem_go & WB_allow);
  assign MEM_to_WB_valid = mem_valid & mem_go;
  assign accept          = EXE_to_MEM_valid & MEM_allow;

  // Occupancy: follows EXE valid whenever the stage can advance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      mem_valid <= 1'b0;
    else if (MEM_allow)
      mem_valid <= EXE_to_MEM_valid;
  end

  // Instruction register: loads only on accept so a stalled instruction is frozen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      bus_r <= '0;
    else if (accept)
      bus_r <= EXE_to_MEM_bus;
  end

  // Marks the first cycle of occupancy, when the SRAM port carries our word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      fresh <= 1'b0;
    else
      fresh <= accept;
  end

  // Keep the SRAM word for replay across WB stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rdata_hold <= '0;
    else if (fresh)
      rdata_hold <= data_sram_rdata;
  end

  assign rd = fresh ? data_sram_rdata : rdata_hold;

  mem_load_ext u_load_ext (
    .rd        (rd),
    .a         (bus_r.alu_result[1:0]),
    .ld        (bus_r.ld),
    .load_data (load_data)
  );

  assign final_result = bus_r.res_from_mem ? load_data : bus_r.alu_result;

  // Assemble WB bus and bypass outputs
  always_comb begin
    mw_bus.gr_we        = bus_r.gr_we;
    mw_bus.dest         = bus_r.dest;
    mw_bus.final_result = final_result;
    mw_bus.pc           = bus_r.pc;
  end

  assign MEM_to_WB_bus = mw_bus;
  assign MEM_dest_bus  = (mem_valid & bus_r.gr_we) ? bus_r.dest : 5'd0;
  assign MEM_value_bus = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases from the load/stall/bypass rules
// followed by random traffic, all checked against a transaction-level model.
module tb_mem_stage;

  typedef struct packed {
    logic        rfm;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  ld;   // {b, bu, h, hu, w}
  } instr_t;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [75:0] in_bus;
  logic        allow;
  logic [31:0] rdata;
  logic        wb_allow;
  logic        wb_valid;
  logic [69:0] wb_bus;
  logic [4:0]  dest_bus;
  logic [31:0] value_bus;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .EXE_to_MEM_valid (in_valid),
    .EXE_to_MEM_bus   (in_bus),
    .MEM_allow        (allow),
    .data_sram_rdata  (rdata),
    .WB_allow         (wb_allow),
    .MEM_to_WB_valid  (wb_valid),
    .MEM_to_WB_bus    (wb_bus),
    .MEM_dest_bus     (dest_bus),
    .MEM_value_bus    (value_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int retire_cnt = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  // model state: what instruction occupies MEM and the word it loaded
  logic        m_valid = 1'b0;
  logic        m_fresh = 1'b0;
  instr_t      m_ins   = '0;
  logic [31:0] m_word  = '0;

  // optional constant checks armed by directed tests for one cycle
  logic        want_en = 1'b0;
  logic [31:0] want_val;
  logic        want_dest_en = 1'b0;
  logic [4:0]  want_dest;

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input instr_t i, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * i.alu[1:0])) & 32'hFF;
    h = (w >> (i.alu[1] ? 16 : 0)) & 32'hFFFF;
    if (i.ld[0]) return w;
    if (i.ld[4]) return (b >= 128) ? b - 32'd256 : b;
    if (i.ld[3]) return b;
    if (i.ld[2]) return (h >= 32768) ? h - 32'd65536 : h;
    if (i.ld[1]) return h;
    return 32'd0;
  endfunction

  function automatic instr_t rand_ins();
    instr_t i;
    i.rfm  = 1'($urandom_range(0, 1));
    i.we   = 1'($urandom_range(0, 1));
    i.dest = 5'($urandom);
    i.alu  = $urandom;
    i.pc   = pc_ctr;
    pc_ctr = pc_ctr + 4;
    i.ld   = i.rfm ? 5'(5'b1 << $urandom_range(0, 4)) : 5'd0;
    return i;
  endfunction

  function automatic instr_t mk(input logic rfm, input logic we, input logic [4:0] d,
                                input logic [31:0] alu, input logic [4:0] ld);
    instr_t i;
    i.rfm = rfm; i.we = we; i.dest = d; i.alu = alu; i.ld = ld;
    i.pc = pc_ctr;
    pc_ctr = pc_ctr + 4;
    return i;
  endfunction

  // One clock: drive inputs, check mid-cycle, advance the model at the edge
  task automatic step(input logic rst, input logic v, input instr_t i,
                      input logic [31:0] rd, input logic wa);
    logic        e_allow;
    logic [31:0] word, res;
    resetn = rst; in_valid = v; in_bus = i; rdata = rd; wb_allow = wa;
    @(negedge clk);
    if (!resetn) begin
      m_valid = 1'b0; m_fresh = 1'b0; m_word = '0;
    end
    e_allow = !m_valid || wb_allow;
    chk("allow", 70'(allow), 70'(e_allow));
    chk("wb_valid", 70'(wb_valid), 70'(m_valid));
    chk("dest_bus", 70'(dest_bus), 70'((m_valid && m_ins.we) ? m_ins.dest : 5'd0));
    if (m_valid) begin
      word = m_fresh ? rdata : m_word;
      res  = m_ins.rfm ? ref_load(m_ins, word) : m_ins.alu;
      chk("wb_bus", wb_bus, {m_ins.we, m_ins.dest, res, m_ins.pc});
      chk("value_bus", 70'(value_bus), 70'(res));
      if (wb_allow) retire_cnt++;
    end
    if (!resetn) chk("rst_bus", wb_bus, 70'd0);
    if (want_en) begin
      chk("directed_value", 70'(value_bus), 70'(want_val));
      want_en = 1'b0;
    end
    if (want_dest_en) begin
      chk("directed_dest", 70'(dest_bus), 70'(want_dest));
      want_dest_en = 1'b0;
    end
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0; m_fresh = 1'b0; m_word = '0;
    end else begin
      if (m_fresh) m_word = rdata;
      m_fresh = e_allow && in_valid;
      if (e_allow) begin
        m_valid = in_valid;
        if (in_valid) m_ins = i;
      end
    end
    #1;
  endtask

  task automatic load_test(input instr_t i, input logic [31:0] w, input logic [31:0] expv);
    step(1'b1, 1'b1, i, $urandom, 1'b1);
    want_en = 1'b1; want_val = expv;
    step(1'b1, 1'b0, rand_ins(), w, 1'b1);
  endtask

  instr_t t;
  int     rc;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_bus = '0; rdata = '0; wb_allow = 1'b0;

    // reset with random inputs, then first valid accepted on the first edge
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'($urandom_range(0, 1)), rand_ins(), $urandom, 1'($urandom_range(0, 1)));
    t = mk(1'b0, 1'b1, 5'd3, 32'hCAFE_0001, 5'd0);
    step(1'b1, 1'b1, t, $urandom, 1'b1);
    want_en = 1'b1; want_val = 32'hCAFE_0001;
    step(1'b1, 1'b0, rand_ins(), $urandom, 1'b1);
    chk("first_accept_retired", 70'(retire_cnt), 70'd1);

    // byte / half / word extraction
    load_test(mk(1'b1, 1'b1, 5'd1, 32'h0000_1003, 5'b10000), 32'h80FF_7F01, 32'hFFFF_FF80);
    load_test(mk(1'b1, 1'b1, 5'd1, 32'h0000_1003, 5'b01000), 32'h80FF_7F01, 32'h0000_0080);
    load_test(mk(1'b1, 1'b1, 5'd2, 32'h0000_2002, 5'b00100), 32'h8001_1234, 32'hFFFF_8001);
    load_test(mk(1'b1, 1'b1, 5'd2, 32'h0000_2000, 5'b00010), 32'h8001_1234, 32'h0000_1234);
    load_test(mk(1'b1, 1'b1, 5'd2, 32'h0000_2000, 5'b00001), 32'h8001_1234, 32'h8001_1234);

    // SRAM word held across a three-cycle WB stall
    t = mk(1'b1, 1'b1, 5'd9, 32'h0000_3000, 5'b00001);
    step(1'b1, 1'b1, t, $urandom, 1'b1);
    rc = retire_cnt;
    want_en = 1'b1; want_val = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, rand_ins(), 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 2; k++) begin
      want_en = 1'b1; want_val = 32'hDEAD_BEEF;
      step(1'b1, 1'b1, rand_ins(), $urandom, 1'b0);
    end
    chk("stall_no_retire", 70'(retire_cnt - rc), 70'd0);
    want_en = 1'b1; want_val = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, rand_ins(), $urandom, 1'b1);
    chk("stall_retire", 70'(retire_cnt - rc), 70'd1);

    // bypass for non-load with and without register write
    step(1'b1, 1'b1, mk(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd0), $urandom, 1'b1);
    want_en = 1'b1; want_val = 32'h1234_5678; want_dest_en = 1'b1; want_dest = 5'd7;
    step(1'b1, 1'b1, mk(1'b0, 1'b0, 5'd7, 32'h1234_5678, 5'd0), $urandom, 1'b1);
    want_en = 1'b1; want_val = 32'h1234_5678; want_dest_en = 1'b1; want_dest = 5'd0;
    step(1'b1, 1'b0, rand_ins(), $urandom, 1'b1);

    // back-to-back traffic: one retire per cycle
    rc = retire_cnt;
    for (int k = 0; k < 8; k++)
      step(1'b1, 1'b1, rand_ins(), $urandom, 1'b1);
    step(1'b1, 1'b0, rand_ins(), $urandom, 1'b1);
    chk("b2b_retires", 70'(retire_cnt - rc), 70'd8);

    // reset during a stall drops the instruction
    step(1'b1, 1'b1, rand_ins(), $urandom, 1'b0);
    step(1'b1, 1'b0, rand_ins(), $urandom, 1'b0);
    step(1'b0, 1'b0, rand_ins(), $urandom, 1'b0);
    rc = retire_cnt;
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, rand_ins(), $urandom, 1'b1);
    chk("dropped_after_reset", 70'(retire_cnt - rc), 70'd0);

    // random traffic with occasional reset
    for (int k = 0; k < 2000; k++)
      step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) < 7),
           rand_ins(), $urandom, 1'($urandom_range(0, 9) < 7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
